// File: rtl/fp_addsub_pkg.sv
// Shared constants and types for the pipelined floating-point adder/subtractor.
package fp_addsub_pkg;

    // Rounding modes; codes 4-7 fall through to round-to-nearest-even.
    localparam logic [2:0] RND_RNE = 3'd0;
    localparam logic [2:0] RND_RTZ = 3'd1;
    localparam logic [2:0] RND_RUP = 3'd2;
    localparam logic [2:0] RND_RDN = 3'd3;

    // Bit positions inside the 8-bit status word; [7:6] are always zero.
    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_INVALID = 2;
    localparam int ST_TINY    = 3;
    localparam int ST_HUGE    = 4;
    localparam int ST_INEXACT = 5;

    // Field widths sized to hold any supported format; the datapath uses the low bits.
    localparam int UNPK_EXP_W = 16;
    localparam int UNPK_SIG_W = 64;

    // Decoded operand: effective exponent, significand with hidden bit, class.
    typedef struct packed {
        logic                  sign;
        logic [UNPK_EXP_W-1:0] exp;
        logic [UNPK_SIG_W-1:0] sig;
        logic                  is_inf;
        logic                  is_nan;
    } fp_unpk_t;

endpackage

// File: rtl/fp_round_norm.sv
// Normalise, round and pack the raw aligned sum from the adder stage.
// sum = {carry, hidden, fraction, guard, round, sticky}.
module fp_round_norm
    import fp_addsub_pkg::*;
#(
    parameter int sig_width       = 23,
    parameter int exp_width       = 8,
    parameter int ieee_compliance = 0
) (
    input  logic                           sign,
    input  logic                           zero_sign,
    input  logic [exp_width-1:0]           exp_in,
    input  logic [sig_width+4:0]           sum,
    input  logic [2:0]                     rnd,
    output logic [sig_width+exp_width:0]   z,
    output logic [7:0]                     status
);
    localparam int P    = sig_width + 1;
    localparam int N    = P + 3;
    localparam int W    = sig_width + exp_width + 1;
    localparam int EMAX = (1 << exp_width) - 1;

    // Leading-zero count of the field below the carry bit.
    function automatic int lzc(input logic [N-1:0] v);
        int n;
        n = N;
        for (int i = 0; i < N; i++)
            if (v[i]) n = N - 1 - i;
        return n;
    endfunction

    logic [N-1:0] norm;
    logic [P:0]   mant_r;
    int           e_n, e_f, lz, shamt;
    logic         inexact, rup, flush;

    // Normalise (limited to exponent 1 for subnormals), round, detect overflow/flush.
    always_comb begin
        norm  = '0;
        e_n   = 0;
        lz    = 0;
        shamt = 0;
        flush = 1'b0;
        if (sum[N]) begin
            norm = {sum[N:2], sum[1] | sum[0]};
            e_n  = int'(exp_in) + 1;
        end else begin
            lz    = lzc(sum[N-1:0]);
            shamt = lz;
            if (lz > int'(exp_in) - 1) begin
                if (ieee_compliance != 0) shamt = int'(exp_in) - 1;
                else                      flush = 1'b1;
            end
            norm = sum[N-1:0] << shamt;
            e_n  = int'(exp_in) - shamt;
        end
        inexact = |norm[2:0];
        case (rnd)
            RND_RTZ: rup = 1'b0;
            RND_RUP: rup = !sign && inexact;
            RND_RDN: rup = sign && inexact;
            default: rup = norm[2] && (norm[1] || norm[0] || norm[3]);
        endcase
        mant_r = {1'b0, norm[N-1:3]} + (P+1)'(rup);
        if (mant_r[P])        e_f = e_n + 1;
        else if (mant_r[P-1]) e_f = e_n;
        else                  e_f = 0;

        z      = {sign, exp_width'(e_f), mant_r[P-2:0]};
        status = '0;
        if (sum == '0) begin
            z                = {zero_sign, {(W-1){1'b0}}};
            status[ST_ZERO]  = 1'b1;
        end else if (flush) begin
            z                   = {sign, {(W-1){1'b0}}};
            status[ST_ZERO]     = 1'b1;
            status[ST_TINY]     = 1'b1;
            status[ST_INEXACT]  = 1'b1;
        end else if (e_f >= EMAX) begin
            status[ST_HUGE]    = 1'b1;
            status[ST_INEXACT] = 1'b1;
            if (rnd == RND_RTZ || (rnd == RND_RUP && sign) || (rnd == RND_RDN && !sign)) begin
                z = {sign, exp_width'(EMAX - 1), {sig_width{1'b1}}};
            end else begin
                z              = {sign, {exp_width{1'b1}}, {sig_width{1'b0}}};
                status[ST_INF] = 1'b1;
            end
        end else begin
            status[ST_INEXACT] = inexact;
            status[ST_TINY]    = (e_f == 0);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE add/subtract: S1 unpack/swap/align, S2 add, S3 round/pack.
// Whole pipe advances together; a held output stalls every stage.
// Optional FP_ADDSUB_STICKY_EN: accumulate status of consumed results.
module fp_addsub_pipe
    import fp_addsub_pkg::*;
#(
    parameter int sig_width       = 23,
    parameter int exp_width       = 8,
    parameter int ieee_compliance = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [sig_width+exp_width:0] inst_a,
    input  logic [sig_width+exp_width:0] inst_b,
    input  logic [2:0]                   inst_rnd,
    input  logic                         inst_op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [sig_width+exp_width:0] z,
    output logic [7:0]                   status,
    input  logic                         clr_sticky,
    output logic [7:0]                   sticky_status
);
    localparam int W      = sig_width + exp_width + 1;
    localparam int P      = sig_width + 1;
    localparam int N      = P + 3;
    localparam int STAGES = 3;
    localparam logic [exp_width-1:0] EXP_ONES = '1;

    typedef struct packed {
        logic [2:0]           rnd;
        logic                 sign;
        logic                 zsign;
        logic                 eff_sub;
        logic [exp_width-1:0] exp;
        logic [N-1:0]         ma;
        logic [N-1:0]         mb;
        logic                 spec;
        logic [W-1:0]         spec_z;
        logic [7:0]           spec_st;
    } s1_t;

    typedef struct packed {
        logic [2:0]           rnd;
        logic                 sign;
        logic                 zsign;
        logic [exp_width-1:0] exp;
        logic [N:0]           sum;
        logic                 spec;
        logic [W-1:0]         spec_z;
        logic [7:0]           spec_st;
    } s2_t;

    logic [STAGES:1]       vld_pipe;
    logic                  adv;
    s1_t                   s1_d, s1_q;
    s2_t                   s2_d, s2_q;
    fp_unpk_t              ua, ub, big, sml;
    logic                  swap, stk;
    logic [UNPK_EXP_W-1:0] d;
    logic [N-1:0]          mb_full, al;
    logic [W-1:0]          rn_z, z_q;
    logic [7:0]            rn_st, st_q;

    assign out_valid = vld_pipe[STAGES];
    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;
    assign z         = z_q;
    assign status    = st_q;

    function automatic fp_unpk_t unpack(input logic [W-1:0] x, input logic flip);
        fp_unpk_t             u;
        logic [exp_width-1:0] e;
        logic [sig_width-1:0] f;
        e        = x[W-2:sig_width];
        f        = x[sig_width-1:0];
        u        = '0;
        u.sign   = x[W-1] ^ flip;
        u.is_inf = (e == EXP_ONES) && (f == '0 || ieee_compliance == 0);
        u.is_nan = (e == EXP_ONES) && (f != '0) && (ieee_compliance != 0);
        if (e != '0) begin
            u.exp = UNPK_EXP_W'(e);
            u.sig = UNPK_SIG_W'({1'b1, f});
        end else if (ieee_compliance != 0) begin
            u.exp = UNPK_EXP_W'(1);
            u.sig = UNPK_SIG_W'({1'b0, f});
        end
        return u;
    endfunction

    // S1: decode, order by magnitude, align the smaller operand keeping a sticky bit.
    always_comb begin
        ua      = unpack(inst_a, 1'b0);
        ub      = unpack(inst_b, inst_op);
        swap    = {ub.exp, ub.sig} > {ua.exp, ua.sig};
        big     = swap ? ub : ua;
        sml     = swap ? ua : ub;
        d       = big.exp - sml.exp;
        mb_full = {sml.sig[P-1:0], 3'b000};
        if (d >= UNPK_EXP_W'(N)) begin
            al  = '0;
            stk = |sml.sig[P-1:0];
        end else begin
            al  = mb_full >> d;
            stk = |(mb_full & ~({N{1'b1}} << d));
        end
        s1_d         = '0;
        s1_d.rnd     = inst_rnd;
        s1_d.sign    = big.sign;
        s1_d.eff_sub = ua.sign ^ ub.sign;
        s1_d.zsign   = s1_d.eff_sub ? (inst_rnd == RND_RDN) : big.sign;
        s1_d.exp     = big.exp[exp_width-1:0];
        s1_d.ma      = {big.sig[P-1:0], 3'b000};
        s1_d.mb      = {al[N-1:1], al[0] | stk};
        if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && s1_d.eff_sub)) begin
            s1_d.spec                 = 1'b1;
            s1_d.spec_st[ST_INVALID]  = 1'b1;
            if (ieee_compliance != 0) begin
                s1_d.spec_z = {1'b0, EXP_ONES, 1'b1, {(sig_width-1){1'b0}}};
            end else begin
                s1_d.spec_z          = {1'b0, EXP_ONES, {sig_width{1'b0}}};
                s1_d.spec_st[ST_INF] = 1'b1;
            end
        end else if (ua.is_inf || ub.is_inf) begin
            s1_d.spec            = 1'b1;
            s1_d.spec_z          = {ua.is_inf ? ua.sign : ub.sign, EXP_ONES, {sig_width{1'b0}}};
            s1_d.spec_st[ST_INF] = 1'b1;
        end
    end

    // S2: signed-magnitude add; the larger magnitude is always the minuend.
    always_comb begin
        s2_d         = '0;
        s2_d.rnd     = s1_q.rnd;
        s2_d.sign    = s1_q.sign;
        s2_d.zsign   = s1_q.zsign;
        s2_d.exp     = s1_q.exp;
        s2_d.sum     = s1_q.eff_sub ? ({1'b0, s1_q.ma} - {1'b0, s1_q.mb})
                                    : ({1'b0, s1_q.ma} + {1'b0, s1_q.mb});
        s2_d.spec    = s1_q.spec;
        s2_d.spec_z  = s1_q.spec_z;
        s2_d.spec_st = s1_q.spec_st;
    end

    // S3: normalise/round.
    fp_round_norm #(
        .sig_width      (sig_width),
        .exp_width      (exp_width),
        .ieee_compliance(ieee_compliance)
    ) u_rn (
        .sign     (s2_q.sign),
        .zero_sign(s2_q.zsign),
        .exp_in   (s2_q.exp),
        .sum      (s2_q.sum),
        .rnd      (s2_q.rnd),
        .z        (rn_z),
        .status   (rn_st)
    );

    // Stage registers: everything moves on adv, everything holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            z_q      <= '0;
            st_q     <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            if (vld_pipe[2]) begin
                z_q  <= s2_q.spec ? s2_q.spec_z  : rn_z;
                st_q <= s2_q.spec ? s2_q.spec_st : rn_st;
            end
        end
    end

`ifdef FP_ADDSUB_STICKY_EN
    logic [7:0] sticky_q;

    // Accumulate flags of consumed results; clear has priority.
    always_ff @(posedge clk) begin
        if (reset || clr_sticky)         sticky_q <= '0;
        else if (out_valid && out_ready) sticky_q <= sticky_q | st_q;
    end

    assign sticky_status = sticky_q;
`else
    assign sticky_status = 8'h00;
`endif

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (binary32 defaults).
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, inst_op, out_valid, out_ready, clr_sticky;
    logic [31:0] inst_a, inst_b, z;
    logic [2:0]  inst_rnd;
    logic [7:0]  status, sticky_status;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sa [10];

    always #5 clk = ~clk;

    fp_addsub_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inst_a       (inst_a),
        .inst_b       (inst_b),
        .inst_rnd     (inst_rnd),
        .inst_op      (inst_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .z            (z),
        .status       (status),
        .clr_sticky   (clr_sticky),
        .sticky_status(sticky_status)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one beat, scramble inputs afterwards, wait for the result.
    task automatic one(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [2:0] rnd,
                       input logic [31:0] ez, input logic [7:0] est);
        int lat;
        @(negedge clk);
        inst_a = a; inst_b = b; inst_op = op; inst_rnd = rnd;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; inst_a = 32'h0; inst_b = 32'h0;
        inst_op = ~op; inst_rnd = rnd ^ 3'd1;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_z"}, z, ez);
        chk({tag, "_st"}, {24'h0, status}, {24'h0, est});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int          sidx, ridx;
        logic [31:0] held;
        sa = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
        inst_a = 32'h0; inst_b = 32'h0; inst_op = 1'b0; inst_rnd = 3'd0;
        held = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ov",     {31'h0, out_valid}, 32'h0);
        chk("rst_z",      z, 32'h0);
        chk("rst_st",     {24'h0, status}, 32'h0);
        chk("rst_sticky", {24'h0, sticky_status}, 32'h0);
        chk("rst_rdy",    {31'h0, in_ready}, 32'h1);

        one("add_1_2",     32'h3F800000, 32'h40000000, 1'b0, 3'd0, 32'h40400000, 8'h00);
        one("sub_eq_rne",  32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 32'h00000000, 8'h01);
        one("sub_eq_rdn",  32'h3F800000, 32'h3F800000, 1'b1, 3'd3, 32'h80000000, 8'h01);
        one("ovf_rne",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 32'h7F800000, 8'h32);
        one("ovf_rtz",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, 32'h7F7FFFFF, 8'h30);
        one("ovf_neg_rup", 32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd2, 32'hFF7FFFFF, 8'h30);
        one("ovf_neg_rdn", 32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd3, 32'hFF800000, 8'h32);
        one("inf_m_inf",   32'h7F800000, 32'h7F800000, 1'b1, 3'd0, 32'h7F800000, 8'h06);
        one("inf_p_one",   32'h7F800000, 32'h3F800000, 1'b0, 3'd0, 32'h7F800000, 8'h02);
        one("tie_rne",     32'h3F800000, 32'h33800000, 1'b0, 3'd0, 32'h3F800000, 8'h20);
        one("tie_rne_odd", 32'h3F800001, 32'h33800000, 1'b0, 3'd0, 32'h3F800002, 8'h20);
        one("tie_rup",     32'h3F800000, 32'h33800000, 1'b0, 3'd2, 32'h3F800001, 8'h20);
        one("tie_rnd5",    32'h3F800000, 32'h33800000, 1'b0, 3'd5, 32'h3F800000, 8'h20);
        one("sub_exact",   32'h3F800000, 32'h33800000, 1'b1, 3'd1, 32'h3F7FFFFF, 8'h00);
        one("mix_sign",    32'hBFC00000, 32'h3F000000, 1'b0, 3'd0, 32'hBF800000, 8'h00);
        one("one_m_two",   32'h3F800000, 32'h40000000, 1'b1, 3'd0, 32'hBF800000, 8'h00);
        one("negz",        32'h80000000, 32'h80000000, 1'b0, 3'd0, 32'h80000000, 8'h01);
        one("denorm_in",   32'h00000001, 32'h00000001, 1'b0, 3'd0, 32'h00000000, 8'h01);
        one("flush_out",   32'h00800001, 32'h00800000, 1'b1, 3'd0, 32'h00000000, 8'h29);

        // Ten back-to-back doublings with the sink stalled for cycles 4-7.
        sidx = 0; ridx = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 7);
            in_valid  = (sidx < 10);
            inst_a    = sa[sidx < 10 ? sidx : 0];
            inst_b    = sa[sidx < 10 ? sidx : 0];
            inst_op   = 1'b0;
            inst_rnd  = 3'd0;
            #1;
            if (out_valid && out_ready) begin
                if (ridx < 10) chk("strm_z", z, sa[ridx] + 32'h00800000);
                ridx++;
            end
            if (out_valid && !out_ready) begin
                chk("strm_rdy", {31'h0, in_ready}, 32'h0);
                if (c == 4) held = z;
                else        chk("strm_hold", z, held);
            end
            if (in_valid && in_ready) sidx++;
        end
        in_valid = 1'b0;
        chk("strm_in",  sidx, 10);
        chk("strm_out", ridx, 10);

        // Fill the pipe with the sink stalled, then reset over it.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; inst_a = sa[k]; inst_b = sa[k];
        end
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                reset = 1'b0; out_ready = 1'b1;
            end
            #1;
            chk("flush_ov",     {31'h0, out_valid}, 32'h0);
            chk("flush_sticky", {24'h0, sticky_status}, 32'h0);
        end
        one("post_rst", 32'h3F800000, 32'h40000000, 1'b0, 3'd0, 32'h40400000, 8'h00);

        // Sticky accumulation after a clear.
        @(negedge clk); clr_sticky = 1'b1;
        @(negedge clk); clr_sticky = 1'b0;
        one("sticky_ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 32'h7F800000, 8'h32);
        @(negedge clk);
`ifdef FP_ADDSUB_STICKY_EN
        chk("sticky_acc", {24'h0, sticky_status}, 32'h32);
`else
        chk("sticky_off", {24'h0, sticky_status}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
